// File: rtl/jt6295_mixn_if.sv
// Port bundle of the serial voice mixer: slot-strobed sample input side and mixed-sample output side.
interface jt6295_mixn_if #(
  parameter int CH = 4,
  parameter int IW = 12,
  parameter int OW = 14
);
  localparam int SW = $clog2(CH);

  logic                 cen;
  logic                 sync;
  logic                 en;
  logic [CH-1:0]        mute;
  logic signed [IW-1:0] sound_in;
  logic [SW-1:0]        slot;
  logic signed [OW-1:0] sound_out;
  logic                 sample;
  logic                 clip;

  modport master (output cen, sync, en, mute, sound_in,
                  input  slot, sound_out, sample, clip);
  modport slave  (input  cen, sync, en, mute, sound_in,
                  output slot, sound_out, sample, clip);
endinterface

// File: rtl/jt6295_mixn.sv
// Serial CH-voice mixer: accumulates one sample per cen, saturates to OW and publishes once per frame.
// Optional output low-pass filter enabled by defining JT6295_MIXN_LPF_EN.
module jt6295_mixn #(
  parameter int CH = 4,
  parameter int IW = 12,
  parameter int OW = 14
) (
  input logic            clk,
  input logic            rst_n,
  jt6295_mixn_if.slave   bus
);
  localparam int SW = $clog2(CH);
  localparam int AW = IW + SW + 1;

  logic [SW-1:0]        slot_q;
  logic signed [AW-1:0] acc;
  logic [SW-1:0]        s_eff;
  logic                 last;
  logic signed [AW-1:0] c;
  logic signed [AW-1:0] sum;
  logic signed [OW-1:0] x;
  logic                 ovf;

  // sync forces the slot being consumed this cycle to be slot 0
  assign s_eff = bus.sync ? '0 : slot_q;
  assign last  = (s_eff == SW'(CH-1));
  assign c     = (bus.en && !bus.mute[s_eff]) ? {{(AW-IW){bus.sound_in[IW-1]}}, bus.sound_in} : '0;
  assign sum   = acc + c;

  generate
    if (AW > OW) begin : g_sat
      // fits in OW bits only when all bits from OW-1 upward agree with the sign
      assign ovf = !((&sum[AW-1:OW-1]) || !(|sum[AW-1:OW-1]));
      assign x   = ovf ? (sum[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
                       : sum[OW-1:0];
    end else begin : g_ext
      assign ovf = 1'b0;
      assign x   = OW'(sum);
    end
  endgenerate

`ifdef JT6295_MIXN_LPF_EN
  localparam int YW = OW + 3;
  logic signed [OW+1:0] y;
  logic signed [OW+1:0] yn;
  assign yn = y + (OW+2)'(((YW'(x) <<< 2) - YW'(y)) >>> 2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      acc           <= '0;
      bus.sound_out <= '0;
      bus.sample    <= 1'b0;
      bus.clip      <= 1'b0;
`ifdef JT6295_MIXN_LPF_EN
      y             <= '0;
`endif
    end else begin
      bus.sample <= 1'b0;
      if (bus.cen) begin
        slot_q <= last ? '0 : s_eff + 1'b1;
        acc    <= (s_eff == '0) ? c : sum;
        if (last) begin
          bus.sample <= 1'b1;
          bus.clip   <= ovf;
`ifdef JT6295_MIXN_LPF_EN
          y             <= yn;
          bus.sound_out <= yn[OW+1:2];
`else
          bus.sound_out <= x;
`endif
        end
      end else if (bus.sync) begin
        slot_q <= '0;
        acc    <= '0;
      end
    end
  end

  assign bus.slot = slot_q;
endmodule
